// File: rtl/tacky_fetch_decode_if.sv
// Fetch/decode port bundle: the master side is the fetch/decode stage, and the slave side
// is the instruction memory plus the execute stage.
interface tacky_fetch_decode_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            halt;
    logic            dec_valid;
    logic            dec_ready;
    logic            dec_long;
    logic [4:0]      dec_op1;
    logic [2:0]      dec_r1;
    logic [4:0]      dec_op2;
    logic [2:0]      dec_r2;
    logic [15:0]     dec_imm16;
    logic [PC_W-1:0] dec_pc;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_long, dec_op1, dec_r1, dec_op2, dec_r2,
               dec_imm16, dec_pc,
        input  imem_data, redirect, redirect_pc, halt, dec_ready
    );
    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_long, dec_op1, dec_r1, dec_op2, dec_r2,
               dec_imm16, dec_pc,
        output imem_data, redirect, redirect_pc, halt, dec_ready
    );
endinterface

// File: rtl/tacky_fetch_decode.sv
// Tacky fetch + decode: a small instruction buffer with pre absorption, redirect and halt.
// Defining FETCH_BYPASS_EN lets a response reach decode in its arrival cycle when the buffer is empty.
module tacky_fetch_decode #(
    parameter int IBUF_DEPTH = 2,
    parameter int PC_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    tacky_fetch_decode_if.master bus
);
    localparam int AW = $clog2(IBUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0] OP_PRE  = 5'b10001;
    localparam logic [4:0] OP_LONG = 5'b10010;

    logic [15:0]     buf_word [IBUF_DEPTH];
    logic [PC_W-1:0] buf_pc   [IBUF_DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count, occ;
    logic [PC_W-1:0] fetch_pc, inflight_pc, head_pc;
    logic            inflight, inflight_epoch, epoch, halted;
    logic [7:0]      pre_reg;
    logic [15:0]     head_word;
    logic            resp_live, redirect_eff, byp, head_present, is_pre, pre_pop;
    logic            valid, long_fmt, hs, push, pop_buf;

    // A response is worth keeping only if its epoch still matches and fetch is not halted.
    assign resp_live    = inflight && (inflight_epoch == epoch) && !halted;
    assign redirect_eff = bus.redirect && !bus.halt && !halted;
`ifdef FETCH_BYPASS_EN
    assign byp = (count == '0) && resp_live;
`else
    assign byp = 1'b0;
`endif
    assign head_present = (count != '0) || byp;
    assign head_word    = byp ? bus.imem_data : buf_word[head];
    assign head_pc      = byp ? inflight_pc   : buf_pc[head];
    assign is_pre       = head_present && (head_word[15:11] == OP_PRE);
    assign valid        = head_present && !is_pre && !halted;
    assign long_fmt     = valid && (head_word[15:11] >= OP_LONG);
    // A pre at the head during a redirect is on the wrong path, so it must not commit.
    assign pre_pop      = is_pre && !halted && !redirect_eff;
    assign hs           = valid && bus.dec_ready;
    assign pop_buf      = (hs || pre_pop) && !byp;
    assign push         = resp_live && !bus.halt && !redirect_eff && !(byp && (hs || pre_pop));
    assign occ          = count + CW'(inflight);

    assign bus.imem_req  = !reset && !halted && !bus.redirect && (occ < CW'(IBUF_DEPTH));
    assign bus.imem_addr = fetch_pc;
    assign bus.dec_valid = valid;
    assign bus.dec_long  = long_fmt;
    assign bus.dec_op1   = valid ? head_word[15:11] : 5'd0;
    assign bus.dec_r1    = valid ? head_word[10:8]  : 3'd0;
    assign bus.dec_op2   = !valid ? 5'd0 : (long_fmt ? 5'b11111 : head_word[7:3]);
    assign bus.dec_r2    = valid ? head_word[2:0]   : 3'd0;
    assign bus.dec_imm16 = long_fmt ? {pre_reg, head_word[7:0]} : 16'd0;
    assign bus.dec_pc    = valid ? head_pc : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc       <= '0;
            inflight_pc    <= '0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
            halted         <= 1'b0;
            pre_reg        <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
        end else begin
            inflight       <= bus.imem_req;
            inflight_pc    <= fetch_pc;
            inflight_epoch <= epoch;
            if (bus.halt) halted <= 1'b1;
            if (redirect_eff) begin
                epoch    <= ~epoch;
                fetch_pc <= bus.redirect_pc;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (bus.imem_req) fetch_pc <= fetch_pc + 1'b1;
                if (pre_pop) pre_reg <= head_word[7:0];
                if (push) tail <= tail + 1'b1;
                if (pop_buf) head <= head + 1'b1;
                count <= count + CW'(push) - CW'(pop_buf);
            end
        end
    end

    // Storage needs no reset: the outputs are masked by dec_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_word[tail] <= bus.imem_data;
            buf_pc[tail]   <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_tacky_fetch_decode.sv
// Directed bench for tacky_fetch_decode using a 256-word instruction memory model.
module tb_tacky_fetch_decode;
    logic clk, reset;
    logic [15:0] mem [256];
    int checks = 0;
    int errors = 0;

    tacky_fetch_decode_if #(.PC_W(16)) bus ();
    tacky_fetch_decode #(.IBUF_DEPTH(2), .PC_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk)
        if (bus.imem_req) bus.imem_data <= mem[bus.imem_addr[7:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = {8'h40, 8'(i)};
    endtask

    task automatic do_reset(input logic rdy);
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.halt = 1'b0;
        bus.dec_ready = rdy;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.dec_valid && n < budget) begin
            step();
            n++;
        end
        if (!bus.dec_valid) check("valid_timeout", 32'(bus.dec_valid), 32'd1);
    endtask

    initial begin
        int reqs, bad;
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.halt = 1'b0;
        bus.dec_ready = 1'b1;
        fill_mem();

        // 1: reset state and basic latency
        mem[0] = 16'h4109;
        step();
        #1;
        check("rst_req",   32'(bus.imem_req),  32'd0);
        check("rst_valid", 32'(bus.dec_valid), 32'd0);
        check("rst_addr",  32'(bus.imem_addr), 32'd0);
        check("rst_imm",   32'(bus.dec_imm16), 32'd0);
        check("rst_op1",   32'(bus.dec_op1),   32'd0);
        step();
        reset = 1'b0;
        #1;
        check("t1_req",  32'(bus.imem_req),  32'd1);
        check("t1_addr", 32'(bus.imem_addr), 32'd0);
        step();
        check("t1_valid_n1", 32'(bus.dec_valid), 32'd0);
        step();
        check("t1_valid_n2", 32'(bus.dec_valid), 32'd1);
        check("t1_op1",  32'(bus.dec_op1), 32'h08);
        check("t1_r1",   32'(bus.dec_r1),  32'd1);
        check("t1_op2",  32'(bus.dec_op2), 32'h01);
        check("t1_r2",   32'(bus.dec_r2),  32'd1);
        check("t1_long", 32'(bus.dec_long), 32'd0);
        check("t1_pc",   32'(bus.dec_pc),  32'd0);

        // 2: pre + long-format bundle
        fill_mem();
        mem[0] = 16'h88AB;
        mem[1] = 16'hA1CD;
        do_reset(1'b1);
        wait_valid(10);
        check("t2_long", 32'(bus.dec_long),  32'd1);
        check("t2_imm",  32'(bus.dec_imm16), 32'hABCD);
        check("t2_pc",   32'(bus.dec_pc),    32'd1);
        check("t2_op2",  32'(bus.dec_op2),   32'h1F);
        check("t2_op1",  32'(bus.dec_op1),   32'h14);

        // 3: backpressure, then in-order drain
        fill_mem();
        do_reset(1'b0);
        reqs = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bus.imem_req) reqs++;
            step();
        end
        check("t3_reqs",  32'(reqs), 32'd2);
        check("t3_hold_valid", 32'(bus.dec_valid), 32'd1);
        check("t3_hold_pc",  32'(bus.dec_pc),  32'd0);
        check("t3_hold_op2", 32'(bus.dec_op2), 32'h00);
        bus.dec_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_valid(20);
            check("t3_order", 32'(bus.dec_pc), 32'(k));
            step();
        end

        // 4: redirect accepted together with the branch at pc 5
        fill_mem();
        do_reset(1'b1);
        for (int k = 0; k < 40 && !(bus.dec_valid && bus.dec_pc == 16'd5); k++) step();
        check("t4_reach5", 32'(bus.dec_pc), 32'd5);
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0040;
        #1;
        check("t4_req_redir", 32'(bus.imem_req), 32'd0);
        step();
        bus.redirect = 1'b0;
        #1;
        check("t4_req_new",  32'(bus.imem_req),  32'd1);
        check("t4_addr_new", 32'(bus.imem_addr), 32'h0040);
        for (int k = 0; k < 3; k++) begin
            wait_valid(20);
            check("t4_pc", 32'(bus.dec_pc), 32'h40 + 32'(k));
            step();
        end

        // 5: PC wrap, then halt beating a same-cycle redirect
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        step();
        bus.redirect = 1'b0;
        #1;
        check("t5_addr_ffff", 32'(bus.imem_addr), 32'hFFFF);
        step();
        check("t5_addr_wrap", 32'(bus.imem_addr), 32'h0000);
        check("t5_req_wrap",  32'(bus.imem_req),  32'd1);
        wait_valid(20);
        check("t5_pc_ffff", 32'(bus.dec_pc), 32'hFFFF);
        step();
        wait_valid(20);
        check("t5_pc_0", 32'(bus.dec_pc), 32'h0000);
        bus.halt = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0080;
        #1;
        check("t5_req_halt", 32'(bus.imem_req), 32'd0);
        step();
        bus.halt = 1'b0;
        bus.redirect = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (bus.imem_req || bus.dec_valid) bad++;
            step();
        end
        check("t5_halted", 32'(bad), 32'd0);
        check("t5_no_redir", 32'(bus.imem_addr == 16'h0080), 32'd0);

        // 6: async reset with a full buffer
        fill_mem();
        mem[0] = 16'h88AB;
        mem[1] = 16'hA1CD;
        do_reset(1'b0);
        for (int k = 0; k < 8; k++) step();
        check("t6_pre_valid", 32'(bus.dec_valid), 32'd1);
        check("t6_pre_imm",   32'(bus.dec_imm16), 32'hABCD);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(bus.dec_valid), 32'd0);
        check("t6_rst_req",   32'(bus.imem_req),  32'd0);
        mem[0] = 16'hA312;
        bus.dec_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        wait_valid(10);
        check("t6_pc",   32'(bus.dec_pc),    32'd0);
        check("t6_long", 32'(bus.dec_long),  32'd1);
        check("t6_imm",  32'(bus.dec_imm16), 32'h0012);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
